// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the text glyph fetcher and a host port; define VRAM_BLANK_ONLY_EN to grant the host only outside active fetch.
module vram_arbiter #(
  parameter int COLS = 80,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int H_SIZE = 800,
  parameter int V_SIZE = 525,
  parameter logic [12:0] FONT_BASE = 13'h1800
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [13:0] hpos,
  input  logic [13:0] vpos,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  glyph_row
);
  typedef enum logic [1:0] {H_IDLE, H_ADDR, H_DATA, H_ACK} hstate_t;
  hstate_t hstate;
  logic [13:0] h8, vn, fc, fl;
  logic [7:0] glyph_next;
  logic [2:0] p;
  logic wrap, fetch, slot_a, slot_b, host_grant;
  // Target is one cell ahead; the last cell of a line points at cell 0 of the next line.
  always_comb begin
    h8 = hpos + 14'd8;
    wrap = h8 >= 14'(H_SIZE);
    fc = wrap ? (h8 - 14'(H_SIZE)) >> 3 : h8 >> 3;
    vn = (vpos + 14'd1 >= 14'(V_SIZE)) ? 14'd0 : vpos + 14'd1;
    fl = wrap ? vn : vpos;
    p = hpos[2:0];
    fetch = fc < 14'(COLS) && fl < 14'(HEIGHT) && {fc[10:0], 3'b000} < 14'(WIDTH);
    slot_a = fetch && p == 3'd0;
    slot_b = fetch && p == 3'd2;
`ifdef VRAM_BLANK_ONLY_EN
    host_grant = host_req && !fetch;
`else
    host_grant = host_req && !slot_a && !slot_b;
`endif
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hstate <= H_IDLE;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      host_ack <= 1'b0;
      host_rdata <= '0;
      glyph_next <= '0;
      glyph_row <= '0;
    end else begin
      mem_we <= 1'b0;
      host_ack <= 1'b0;
      case (hstate)
        H_IDLE: if (host_grant) begin
          hstate <= H_ADDR;
          mem_addr <= host_addr;
          mem_we <= host_we;
          mem_wdata <= host_wdata;
        end
        H_ADDR: hstate <= H_DATA;
        H_DATA: begin
          hstate <= H_ACK;
          host_rdata <= mem_rdata;
          host_ack <= 1'b1;
        end
        default: hstate <= H_IDLE;
      endcase
      if (slot_a) mem_addr <= 13'(14'(fl[8:3]) * 14'(COLS) + fc);
      if (slot_b) mem_addr <= FONT_BASE + {2'b00, mem_rdata, fl[2:0]};
      if (p == 3'd0 && !fetch) glyph_next <= '0;
      if (fetch && p == 3'd4) glyph_next <= mem_rdata;
      if (p == 3'd7) glyph_row <= glyph_next;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench with a behavioural VRAM and a shadow copy of its expected contents.
module tb_vram_arbiter;
  logic clk_in = 0, rst = 1;
  logic [13:0] hpos = 0, vpos = 0;
  logic host_req = 0, host_we = 0;
  logic [12:0] host_addr = 0;
  logic [7:0] host_wdata = 0;
  logic host_ack, mem_we;
  logic [7:0] host_rdata, mem_wdata, mem_rdata, glyph_row;
  logic [12:0] mem_addr;
  logic [7:0] ram [0:8191];
  logic [7:0] shadow [0:8191];
  logic [7:0] gq [$];
  logic [7:0] rq [$];
  int n_checks = 0, n_errors = 0;
`ifdef VRAM_BLANK_ONLY_EN
  localparam int HI = 800;
  localparam int BLANK_LAT = 535;
`else
  localparam int HI = 4;
  localparam int BLANK_LAT = 3;
`endif

  vram_arbiter dut (
    .clk_in(clk_in), .rst(rst), .hpos(hpos), .vpos(vpos),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .glyph_row(glyph_row)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void target(input int h, input int v, output bit act, output int c, output int l);
    int h8 = h + 8;
    if (h8 < 800) begin
      c = h8 / 8;
      l = v;
    end else begin
      c = (h8 - 800) / 8;
      l = (v + 1 == 525) ? 0 : v + 1;
    end
    act = c < 80 && l < 480;
  endfunction

  task automatic set_pos(input int h, input int v);
    hpos = 14'(h);
    vpos = 14'(v);
    gq.delete();
  endtask

  task automatic step();
    int h, v, c, l, ca, fa;
    bit act;
    @(posedge clk_in);
    #1;
    h = int'(hpos);
    v = int'(vpos);
    if (!rst) begin
      target(h, v, act, c, l);
      ca = (l / 8) * 80 + c;
      fa = act ? 'h1800 + int'(shadow[ca]) * 8 + l % 8 : 0;
      if (h % 8 == 0) gq.push_back(act ? shadow[fa] : 8'h00);
      if (act && (h % 8 == 0 || h % 8 == 2)) check("vid_we", 32'(mem_we), 0);
      if (act && h % 8 == 0) check("vid_char", 32'(mem_addr), ca);
      if (act && h % 8 == 2) check("vid_font", 32'(mem_addr), fa);
      if (h % 8 == 7 && gq.size() > 0) check("glyph_row", 32'(glyph_row), 32'(gq.pop_front()));
    end
    if (hpos == 14'd799) begin
      hpos = 0;
      vpos = (vpos == 14'd524) ? 14'd0 : vpos + 14'd1;
    end else hpos = hpos + 14'd1;
  endtask

  task automatic check_reset();
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_glyph_row", 32'(glyph_row), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);
  endtask

  task automatic host_txn(input bit we, input logic [12:0] a, input logic [7:0] d, input int lo, input int hi);
    int n = 0;
    host_req = 1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    if (we) shadow[a] = d;
    else rq.push_back(shadow[a]);
    do begin
      step();
      n++;
    end while (!host_ack && n < 2000);
    check("ack_seen", 32'(host_ack), 1);
    if (lo == hi) check("ack_lat", n, lo);
    else check("ack_lat_range", 32'(n >= lo && n <= hi), 1);
    if (!we && host_ack) check("host_rdata", 32'(host_rdata), 32'(rq.pop_front()));
    host_req = 0;
  endtask

  initial begin
    int n, last, acks;
    logic [12:0] a;
    logic [7:0] d;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    ram[0] = 8'h41;
    shadow[0] = 8'h41;
    ram['h1A08] = 8'hC6;
    shadow['h1A08] = 8'hC6;
    repeat (3) step();
    check_reset();
    rst = 0;
    // reset in the middle of a host read: outputs clear and no ack follows
    set_pos(100, 10);
    host_req = 1;
    host_we = 0;
    host_addr = 13'h1350;
    step();
    step();
    rst = 1;
    #1;
    check_reset();
    repeat (3) begin
      step();
      check("rst_no_ack", 32'(host_ack), 0);
    end
    host_req = 0;
    rst = 0;
    gq.delete();
    step();
    // host write then read back during active display
    set_pos(96, 10);
    host_txn(1, 13'h0123, 8'h5A, 3, HI);
    host_txn(0, 13'h0123, 8'h00, 3, HI);
    for (int i = 0; i < 6; i++) begin
      a = 13'($urandom_range(32'h1300, 32'h17FF));
      d = 8'($urandom);
      host_txn(1, a, d, 3, HI);
      repeat ($urandom_range(0, 3)) step();
      host_txn(0, a, 8'h00, 3, HI);
    end
`ifndef VRAM_BLANK_ONLY_EN
    // request first seen on a video slot edge: grant on the following edge
    set_pos(96, 10);
    host_req = 1;
    host_we = 0;
    host_addr = 13'h1357;
    rq.push_back(shadow['h1357]);
    step();
    step();
    check("coll_grant", 32'(mem_addr), 32'h1357);
    n = 2;
    while (!host_ack && n < 100) begin
      step();
      n++;
    end
    check("coll_lat", n, 4);
    check("coll_rdata", 32'(host_rdata), 32'(rq.pop_front()));
    host_req = 0;
    step();
`endif
    // first cell of line 0 is fetched at the end of the last line
    set_pos(792, 524);
    step();
    check("g_char0", 32'(mem_addr), 0);
    step();
    step();
    check("g_font", 32'(mem_addr), 32'h1A08);
    repeat (5) step();
    check("g_row", 32'(glyph_row), 32'hC6);
    repeat (200) step();
    // blanking: back-to-back reads every 4 edges, glyph rows zero
    set_pos(0, 500);
    host_req = 1;
    host_we = 0;
    host_addr = 13'h1400;
    rq.push_back(shadow['h1400]);
    n = 0;
    last = 0;
    acks = 0;
    while (acks < 5 && n < 100) begin
      step();
      n++;
      if (host_ack) begin
        check("b2b_rdata", 32'(host_rdata), 32'(rq.pop_front()));
        if (acks == 0) check("b2b_first", n, 3);
        else check("b2b_gap", n - last, 4);
        last = n;
        acks++;
        if (acks < 5) rq.push_back(shadow['h1400]);
      end
    end
    check("b2b_acks", acks, 5);
    host_req = 0;
    repeat (20) step();
    // request in the middle of an active line
    set_pos(100, 10);
    host_txn(0, 13'h1500, 8'h00, BLANK_LAT, BLANK_LAT);
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
